// File: rtl/pgm_gen_sched.sv
// Replays the packet held in PGM_RAM a programmable number of times with an inter-packet gap,
// sharing the output port with the bypass path at packet boundaries. PGM_SCHED_TS_EN: timestamp word 1.
module pgm_gen_sched #(
    parameter int unsigned AW    = 7,
    parameter int unsigned GAP_W = 16,
    parameter int unsigned CNT_W = 32,
    localparam int unsigned DW    = 134,
    localparam int unsigned RAM_W = 144
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             soft_rst,
    input  logic             gen_start,
    input  logic             gen_stop,
    input  logic [AW-1:0]    pkt_last_addr,
    input  logic [CNT_W-1:0] cfg_pkt_num,
    input  logic [GAP_W-1:0] cfg_gap,
    output logic             ram_rd_en,
    output logic [AW-1:0]    ram_rd_addr,
    input  logic [RAM_W-1:0] ram_rd_data,
    input  logic             byp_req,
    output logic             byp_gnt,
    input  logic [DW-1:0]    byp_data,
    input  logic             byp_data_wr,
    input  logic             byp_valid,
    input  logic             byp_valid_wr,
    input  logic             in_alf,
    output logic [DW-1:0]    out_data,
    output logic             out_data_wr,
    output logic             out_valid,
    output logic             out_valid_wr,
    output logic             gen_busy,
    output logic             gen_finish,
    output logic [CNT_W-1:0] sent_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_RD, S_GAP, S_BYP, S_DONE} state_e;

    state_e           state_q, state_d;
    logic             rd_en_q, rd_en_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic             rd_vld_q, rd_vld_d;
    logic             rd_last_q, rd_last_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic             out_data_wr_q, out_data_wr_d;
    logic             out_valid_q, out_valid_d;
    logic             out_valid_wr_q, out_valid_wr_d;
    logic             byp_gnt_q, byp_gnt_d;
    logic             gen_busy_q, gen_busy_d;
    logic             gen_finish_q, gen_finish_d;
    logic             stop_q, stop_d;
    logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d, sent_inc;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [DW-1:0]    rd_word;
    logic             unused_rd_bits;

`ifdef PGM_SCHED_TS_EN
    logic [63:0]      ts_cnt_q, ts_cnt_d;
    logic [AW-1:0]    rd_vld_addr_q, rd_vld_addr_d;
`endif

    assign unused_rd_bits = ^ram_rd_data[RAM_W-1:DW];
    assign sent_inc       = (&sent_cnt_q) ? sent_cnt_q : sent_cnt_q + CNT_W'(1);

    // RAM word as it leaves the block; optionally stamped on address 1
    always_comb begin
        rd_word = ram_rd_data[DW-1:0];
`ifdef PGM_SCHED_TS_EN
        if (rd_vld_addr_q == AW'(1)) begin
            rd_word[63:0] = ts_cnt_q + 64'd1;
        end
`endif
    end

    always_comb begin
        state_d        = state_q;
        rd_en_d        = 1'b0;
        rd_addr_d      = rd_addr_q;
        rd_vld_d       = rd_en_q;
        rd_last_d      = rd_en_q && (rd_addr_q == pkt_last_addr);
        out_data_d     = out_data_q;
        out_data_wr_d  = 1'b0;
        out_valid_d    = 1'b0;
        out_valid_wr_d = 1'b0;
        byp_gnt_d      = 1'b0;
        gen_busy_d     = gen_busy_q;
        gen_finish_d   = 1'b0;
        sent_cnt_d     = sent_cnt_q;
        stop_d         = stop_q | (gen_stop & gen_busy_q);
        gap_cnt_d      = gap_cnt_q;
`ifdef PGM_SCHED_TS_EN
        ts_cnt_d       = ts_cnt_q + 64'd1;
        rd_vld_addr_d  = rd_addr_q;
`endif

        case (state_q)
            S_IDLE: begin
                // a start arriving with a bypass request is remembered through gen_busy
                if (gen_start) begin
                    gen_busy_d = 1'b1;
                    sent_cnt_d = '0;
                    stop_d     = 1'b0;
                end
                if (byp_req) begin
                    byp_gnt_d = 1'b1;
                    state_d   = S_BYP;
                end else if (gen_start) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (byp_req) begin
                    byp_gnt_d = 1'b1;
                    state_d   = S_BYP;
                end else if (stop_d) begin
                    state_d = S_DONE;
                end else if (!in_alf) begin
                    state_d   = S_RD;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                end
            end
            S_RD: begin
                if (rd_en_q && rd_addr_q != pkt_last_addr) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + AW'(1);
                end
                if (rd_vld_q) begin
                    out_data_d    = rd_word;
                    out_data_wr_d = 1'b1;
                    if (rd_last_q) begin
                        out_valid_d    = 1'b1;
                        out_valid_wr_d = 1'b1;
                        sent_cnt_d     = sent_inc;
                        if (stop_d || (cfg_pkt_num != '0 && sent_inc == cfg_pkt_num)) begin
                            state_d = S_DONE;
                        end else if (cfg_gap == '0) begin
                            state_d = S_ARB;
                        end else begin
                            state_d   = S_GAP;
                            gap_cnt_d = '0;
                        end
                    end
                end
            end
            S_GAP: begin
                if (stop_d) begin
                    state_d = S_DONE;
                end else if (gap_cnt_q == cfg_gap - GAP_W'(1)) begin
                    state_d = S_ARB;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            S_BYP: begin
                out_data_d     = byp_data;
                out_data_wr_d  = byp_data_wr;
                out_valid_d    = byp_valid;
                out_valid_wr_d = byp_valid_wr;
                if (byp_valid_wr) begin
                    state_d = gen_busy_q ? S_ARB : S_IDLE;
                end
            end
            S_DONE: begin
                gen_finish_d = 1'b1;
                gen_busy_d   = 1'b0;
                stop_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // synchronous clear aborts any packet in flight
        if (soft_rst) begin
            state_d        = S_IDLE;
            rd_en_d        = 1'b0;
            rd_addr_d      = '0;
            rd_vld_d       = 1'b0;
            rd_last_d      = 1'b0;
            out_data_d     = '0;
            out_data_wr_d  = 1'b0;
            out_valid_d    = 1'b0;
            out_valid_wr_d = 1'b0;
            byp_gnt_d      = 1'b0;
            gen_busy_d     = 1'b0;
            gen_finish_d   = 1'b0;
            sent_cnt_d     = '0;
            stop_d         = 1'b0;
            gap_cnt_d      = '0;
`ifdef PGM_SCHED_TS_EN
            ts_cnt_d       = '0;
            rd_vld_addr_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            rd_en_q        <= 1'b0;
            rd_addr_q      <= '0;
            rd_vld_q       <= 1'b0;
            rd_last_q      <= 1'b0;
            out_data_q     <= '0;
            out_data_wr_q  <= 1'b0;
            out_valid_q    <= 1'b0;
            out_valid_wr_q <= 1'b0;
            byp_gnt_q      <= 1'b0;
            gen_busy_q     <= 1'b0;
            gen_finish_q   <= 1'b0;
            sent_cnt_q     <= '0;
            stop_q         <= 1'b0;
            gap_cnt_q      <= '0;
`ifdef PGM_SCHED_TS_EN
            ts_cnt_q       <= '0;
            rd_vld_addr_q  <= '0;
`endif
        end else begin
            state_q        <= state_d;
            rd_en_q        <= rd_en_d;
            rd_addr_q      <= rd_addr_d;
            rd_vld_q       <= rd_vld_d;
            rd_last_q      <= rd_last_d;
            out_data_q     <= out_data_d;
            out_data_wr_q  <= out_data_wr_d;
            out_valid_q    <= out_valid_d;
            out_valid_wr_q <= out_valid_wr_d;
            byp_gnt_q      <= byp_gnt_d;
            gen_busy_q     <= gen_busy_d;
            gen_finish_q   <= gen_finish_d;
            sent_cnt_q     <= sent_cnt_d;
            stop_q         <= stop_d;
            gap_cnt_q      <= gap_cnt_d;
`ifdef PGM_SCHED_TS_EN
            ts_cnt_q       <= ts_cnt_d;
            rd_vld_addr_q  <= rd_vld_addr_d;
`endif
        end
    end

    assign ram_rd_en    = rd_en_q;
    assign ram_rd_addr  = rd_addr_q;
    assign out_data     = out_data_q;
    assign out_data_wr  = out_data_wr_q;
    assign out_valid    = out_valid_q;
    assign out_valid_wr = out_valid_wr_q;
    assign byp_gnt      = byp_gnt_q;
    assign gen_busy     = gen_busy_q;
    assign gen_finish   = gen_finish_q;
    assign sent_cnt     = sent_cnt_q;

endmodule

// File: tb/tb_pgm_gen_sched.sv
// Scoreboard bench for pgm_gen_sched: expected words are queued as stimulus is driven and
// popped as the DUT emits them; timing of gaps, grants and finish is checked from recorded cycles.
module tb_pgm_gen_sched;
    localparam int unsigned AW    = 7;
    localparam int unsigned GAP_W = 16;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned DW    = 134;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          ts;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             soft_rst = 1'b0;
    logic             gen_start = 1'b0;
    logic             gen_stop = 1'b0;
    logic [AW-1:0]    pkt_last_addr = '0;
    logic [CNT_W-1:0] cfg_pkt_num = '0;
    logic [GAP_W-1:0] cfg_gap = '0;
    logic             ram_rd_en;
    logic [AW-1:0]    ram_rd_addr;
    logic [143:0]     ram_rd_data;
    logic             byp_req = 1'b0;
    logic             byp_gnt;
    logic [DW-1:0]    byp_data = '0;
    logic             byp_data_wr = 1'b0;
    logic             byp_valid = 1'b0;
    logic             byp_valid_wr = 1'b0;
    logic             in_alf = 1'b0;
    logic [DW-1:0]    out_data;
    logic             out_data_wr;
    logic             out_valid;
    logic             out_valid_wr;
    logic             gen_busy;
    logic             gen_finish;
    logic [CNT_W-1:0] sent_cnt;

    logic [143:0] ram [0:127];
    exp_t         exp_q[$];
    int           vwr_cyc[$];
    int           swr_cyc[$];
    int           n_assert = 0;
    int           n_fail = 0;
    int           n_rd = 0;
    int           n_wr = 0;
    int           n_gnt = 0;
    int           n_fin = 0;
    int           cyc = 0;
    int           gnt_cyc = 0;
    int           fin_cyc = 0;
    logic         pkt_start = 1'b1;
    logic [63:0]  last_ts = '0;

    pgm_gen_sched #(.AW(AW), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst),
        .gen_start(gen_start), .gen_stop(gen_stop),
        .pkt_last_addr(pkt_last_addr), .cfg_pkt_num(cfg_pkt_num), .cfg_gap(cfg_gap),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .byp_req(byp_req), .byp_gnt(byp_gnt), .byp_data(byp_data),
        .byp_data_wr(byp_data_wr), .byp_valid(byp_valid), .byp_valid_wr(byp_valid_wr),
        .in_alf(in_alf), .out_data(out_data), .out_data_wr(out_data_wr),
        .out_valid(out_valid), .out_valid_wr(out_valid_wr),
        .gen_busy(gen_busy), .gen_finish(gen_finish), .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous-read RAM model, one cycle of latency
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
    end

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] byp_word(input int b, input int i);
        byp_word = {6'h2A, 64'(b) * 64'h9E37_79B9_7F4A_7C15, 32'(i), 32'hB00B_0000 | 32'(i)};
    endfunction

    // output monitor: pops the scoreboard on every output word
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (ram_rd_en) n_rd++;
            if (byp_gnt) begin n_gnt++; gnt_cyc = cyc; end
            if (gen_finish) begin n_fin++; fin_cyc = cyc; end
            if (out_data_wr) begin
                n_wr++;
                if (pkt_start) swr_cyc.push_back(cyc);
                pkt_start = out_valid_wr;
                if (exp_q.size() == 0) begin
                    check_val("stray_word", DW'(out_data_wr), DW'(0));
                end else begin
                    e = exp_q.pop_front();
`ifdef PGM_SCHED_TS_EN
                    if (e.ts) begin
                        check_val("ts_upper", DW'(out_data[DW-1:64]), DW'(e.data[DW-1:64]));
                        check_val("ts_incr", DW'(out_data[63:0] > last_ts), DW'(1));
                        last_ts = out_data[63:0];
                    end else begin
                        check_val("out_data", out_data, e.data);
                    end
`else
                    check_val("out_data", out_data, e.data);
`endif
                    check_val("valid_wr_pos", DW'(out_valid_wr), DW'(e.last));
                    if (e.last) check_val("valid_bit", DW'(out_valid), DW'(1));
                end
            end else if (out_valid_wr) begin
                check_val("stray_valid_wr", DW'(out_valid_wr), DW'(0));
            end
            if (out_valid_wr) vwr_cyc.push_back(cyc);
            if (soft_rst) begin
                pkt_start = 1'b1;
                last_ts   = '0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_gen(input int last, input int npk);
        for (int p = 0; p < npk; p++) begin
            for (int a = 0; a <= last; a++) begin
                exp_t e;
                e.data = ram[a][DW-1:0];
                e.last = (a == last);
                e.ts   = (a == 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_byp(input int b, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.data = byp_word(b, i);
            e.last = (i == n - 1);
            e.ts   = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_byp(input int b, input int n);
        int k = 0;
        byp_req = 1'b1;
        while (k < 300 && !byp_gnt) begin tick(1); k++; end
        check_val("byp_gnt_seen", DW'(byp_gnt), DW'(1));
        byp_req = 1'b0;
        if (byp_gnt) begin
            for (int i = 0; i < n; i++) begin
                tick(1);
                byp_data     = byp_word(b, i);
                byp_data_wr  = 1'b1;
                byp_valid    = (i == n - 1);
                byp_valid_wr = (i == n - 1);
            end
            tick(1);
            byp_data_wr  = 1'b0;
            byp_valid    = 1'b0;
            byp_valid_wr = 1'b0;
        end
    endtask

    task automatic start_gen(input int last, input int num, input int gap);
        pkt_last_addr = AW'(last);
        cfg_pkt_num   = CNT_W'(num);
        cfg_gap       = GAP_W'(gap);
        gen_start     = 1'b1;
        tick(1);
        gen_start     = 1'b0;
    endtask

    task automatic wait_fin(input int budget);
        int f0 = n_fin;
        int k = 0;
        while (k < budget && n_fin == f0) begin tick(1); k++; end
        check_val("finish_seen", DW'(n_fin - f0), DW'(1));
    endtask

    task automatic wait_vwr(input int target, input int budget);
        int k = 0;
        while (k < budget && vwr_cyc.size() < target) begin tick(1); k++; end
        check_val("valid_wr_reached", DW'(vwr_cyc.size() >= target), DW'(1));
    endtask

    task automatic wait_wr(input int target, input int budget);
        int k = 0;
        while (k < budget && n_wr < target) begin tick(1); k++; end
        check_val("words_reached", DW'(n_wr >= target), DW'(1));
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (k < budget && exp_q.size() != 0) begin tick(1); k++; end
        check_val("scoreboard_drained", DW'(exp_q.size()), DW'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int v0, s0, w0, g0, r0, w1;
        for (int i = 0; i < 128; i++) begin
            ram[i] = {16'(i) ^ 16'hBEEF, $urandom, $urandom, $urandom, $urandom};
        end

        // reset state
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check_val("rst_ram_rd_en", DW'(ram_rd_en), DW'(0));
        check_val("rst_out_data_wr", DW'(out_data_wr), DW'(0));
        check_val("rst_out_valid_wr", DW'(out_valid_wr), DW'(0));
        check_val("rst_out_data", out_data, DW'(0));
        check_val("rst_byp_gnt", DW'(byp_gnt), DW'(0));
        check_val("rst_gen_busy", DW'(gen_busy), DW'(0));
        check_val("rst_gen_finish", DW'(gen_finish), DW'(0));
        check_val("rst_sent_cnt", DW'(sent_cnt), DW'(0));

        // two 4-word packets, gap 5; a second gen_start while busy must be ignored
        v0 = vwr_cyc.size(); s0 = swr_cyc.size();
        push_gen(3, 2);
        start_gen(3, 2, 5);
        check_val("busy_after_start", DW'(gen_busy), DW'(1));
        wait_vwr(v0 + 1, 100);
        gen_start = 1'b1; tick(1); gen_start = 1'b0;
        wait_fin(200);
        check_val("t1_pkt_count", DW'(vwr_cyc.size() - v0), DW'(2));
        // restart costs the gap plus ARB and the RAM read latency
        check_val("t1_gap_cycles", DW'(swr_cyc[s0+1] - vwr_cyc[v0]), DW'(5 + 3));
        check_val("t1_finish_lat", DW'(fin_cyc - vwr_cyc[v0+1]), DW'(1));
        check_val("t1_finish_pulse", DW'(gen_finish), DW'(0));
        check_val("t1_sent_cnt", DW'(sent_cnt), DW'(2));
        check_val("t1_busy_clear", DW'(gen_busy), DW'(0));
        wait_drain(0);

        // bypass request during packet 1 of 3
        v0 = vwr_cyc.size(); g0 = n_gnt; w0 = n_wr;
        push_gen(2, 1);
        push_byp(1, 3);
        push_gen(2, 2);
        fork
            begin start_gen(2, 3, 2); wait_fin(400); end
            begin wait_wr(w0 + 1, 100); send_byp(1, 3); end
        join
        check_val("t2_gnt_count", DW'(n_gnt - g0), DW'(1));
        check_val("t2_gnt_after_pkt1", DW'(gnt_cyc > vwr_cyc[v0]), DW'(1));
        check_val("t2_sent_cnt", DW'(sent_cnt), DW'(3));
        wait_drain(0);

        // in_alf holds ARB; a packet in flight is not stalled
        w0 = n_wr; r0 = n_rd;
        in_alf = 1'b1;
        push_gen(3, 1);
        start_gen(3, 1, 0);
        tick(10);
        check_val("t3_no_read", DW'(n_rd - r0), DW'(0));
        check_val("t3_no_output", DW'(n_wr - w0), DW'(0));
        in_alf = 1'b0;
        tick(1);
        check_val("t3_rd_start", DW'(ram_rd_en), DW'(1));
        check_val("t3_rd_addr0", DW'(ram_rd_addr), DW'(0));
        in_alf = 1'b1;
        wait_fin(100);
        in_alf = 1'b0;
        check_val("t3_sent_cnt", DW'(sent_cnt), DW'(1));
        wait_drain(0);

        // unlimited packets, stop after the 7th
        v0 = vwr_cyc.size();
        push_gen(1, 7);
        start_gen(1, 0, 4);
        wait_vwr(v0 + 7, 400);
        gen_stop = 1'b1; tick(1); gen_stop = 1'b0;
        wait_fin(100);
        check_val("t4_pkt_count", DW'(vwr_cyc.size() - v0), DW'(7));
        check_val("t4_sent_cnt", DW'(sent_cnt), DW'(7));
        wait_drain(0);

        // soft reset in the middle of an 8-word packet
        w0 = n_wr; v0 = vwr_cyc.size();
        push_gen(7, 1);
        start_gen(7, 1, 0);
        wait_wr(w0 + 2, 100);
        soft_rst = 1'b1;
        tick(1);
        check_val("t5_out_data_wr", DW'(out_data_wr), DW'(0));
        check_val("t5_out_valid_wr", DW'(out_valid_wr), DW'(0));
        check_val("t5_out_data", out_data, DW'(0));
        check_val("t5_ram_rd_en", DW'(ram_rd_en), DW'(0));
        check_val("t5_ram_rd_addr", DW'(ram_rd_addr), DW'(0));
        check_val("t5_gen_busy", DW'(gen_busy), DW'(0));
        check_val("t5_sent_cnt", DW'(sent_cnt), DW'(0));
        soft_rst = 1'b0;
        exp_q.delete();
        w1 = n_wr;
        tick(20);
        check_val("t5_quiet_after", DW'(n_wr - w1), DW'(0));
        check_val("t5_no_valid_wr", DW'(vwr_cyc.size() - v0), DW'(0));

        // single-word packets
        v0 = vwr_cyc.size(); s0 = swr_cyc.size();
        push_gen(0, 2);
        start_gen(0, 2, 0);
        wait_fin(100);
        check_val("t6_same_cycle", DW'(swr_cyc[s0] - vwr_cyc[v0]), DW'(0));
        check_val("t6_zero_gap", DW'(swr_cyc[s0+1] - vwr_cyc[v0]), DW'(3));
        check_val("t6_sent_cnt", DW'(sent_cnt), DW'(2));
        wait_drain(0);

        // bypass from idle leaves the generator untouched
        g0 = n_gnt;
        push_byp(2, 4);
        send_byp(2, 4);
        wait_drain(50);
        check_val("t7_gnt_count", DW'(n_gnt - g0), DW'(1));
        check_val("t7_busy", DW'(gen_busy), DW'(0));

        // simultaneous gen_start and byp_req: bypass first, then the packet
        push_byp(3, 2);
        push_gen(1, 1);
        pkt_last_addr = AW'(1);
        cfg_pkt_num   = CNT_W'(1);
        cfg_gap       = GAP_W'(0);
        gen_start     = 1'b1;
        fork
            send_byp(3, 2);
            begin tick(1); gen_start = 1'b0; end
        join
        wait_fin(200);
        check_val("t8_sent_cnt", DW'(sent_cnt), DW'(1));
        wait_drain(0);

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
